// File: rtl/exe_operand_stage.sv
// Execute-stage operand register: captures the decoded instruction, forwards
// operands from the memory/write-back stages and inserts load-use bubbles.
module exe_operand_stage #(
  parameter int WIDTH = 32,
  parameter int RADDR = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             freeze,
  input  logic             flush,
  input  logic             id_valid,
  input  logic [3:0]       id_cmd,
  input  logic [WIDTH-1:0] id_val_rn,
  input  logic [WIDTH-1:0] id_val_rm,
  input  logic [WIDTH-1:0] id_imm,
  input  logic             id_imm_sel,
  input  logic [RADDR-1:0] id_src1,
  input  logic [RADDR-1:0] id_src2,
  input  logic [RADDR-1:0] id_dest,
  input  logic             id_wb_en,
  input  logic             id_mem_r,
  input  logic             id_mem_w,
  input  logic             mem_wb_en,
  input  logic [RADDR-1:0] mem_dest,
  input  logic [WIDTH-1:0] mem_value,
  input  logic             wb_wb_en,
  input  logic [RADDR-1:0] wb_dest,
  input  logic [WIDTH-1:0] wb_value,
  output logic             stall_out,
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  output logic [3:0]       alu_cmd,
  output logic [WIDTH-1:0] ex_store_val,
  output logic             ex_valid,
  output logic             ex_wb_en,
  output logic             ex_mem_r,
  output logic             ex_mem_w,
  output logic [RADDR-1:0] ex_dest,
  output logic [CNT_W-1:0] bubble_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             valid_q;
  logic [3:0]       cmd_q;
  logic [WIDTH-1:0] rn_q;
  logic [WIDTH-1:0] rm_q;
  logic [WIDTH-1:0] imm_q;
  logic             imm_sel_q;
  logic [RADDR-1:0] src1_q;
  logic [RADDR-1:0] src2_q;
  logic [RADDR-1:0] dest_q;
  logic             wb_en_q;
  logic             mem_r_q;
  logic             mem_w_q;
  logic [CNT_W-1:0] cnt_q;

  logic             hazard;
  logic             counted_bubble;
  logic             load_bubble;
  logic [WIDTH-1:0] fwd_rn;
  logic [WIDTH-1:0] fwd_rm;

  // A load in this stage cannot forward its data yet, so any consumer of its
  // destination in decode must wait one cycle.
  always_comb begin
    hazard         = valid_q & mem_r_q & id_valid &
                     ((id_src1 == dest_q) | (~id_imm_sel & (id_src2 == dest_q)));
    counted_bubble = flush | hazard;
    load_bubble    = counted_bubble | ~id_valid;
    stall_out      = freeze | (hazard & ~flush);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      cmd_q     <= '0;
      rn_q      <= '0;
      rm_q      <= '0;
      imm_q     <= '0;
      imm_sel_q <= 1'b0;
      src1_q    <= '0;
      src2_q    <= '0;
      dest_q    <= '0;
      wb_en_q   <= 1'b0;
      mem_r_q   <= 1'b0;
      mem_w_q   <= 1'b0;
      cnt_q     <= '0;
    end else if (!freeze) begin
      if (load_bubble) begin
        valid_q   <= 1'b0;
        cmd_q     <= '0;
        rn_q      <= '0;
        rm_q      <= '0;
        imm_q     <= '0;
        imm_sel_q <= 1'b0;
        src1_q    <= '0;
        src2_q    <= '0;
        dest_q    <= '0;
        wb_en_q   <= 1'b0;
        mem_r_q   <= 1'b0;
        mem_w_q   <= 1'b0;
      end else begin
        valid_q   <= 1'b1;
        cmd_q     <= id_cmd;
        rn_q      <= id_val_rn;
        rm_q      <= id_val_rm;
        imm_q     <= id_imm;
        imm_sel_q <= id_imm_sel;
        src1_q    <= id_src1;
        src2_q    <= id_src2;
        dest_q    <= id_dest;
        wb_en_q   <= id_wb_en;
        mem_r_q   <= id_mem_r;
        mem_w_q   <= id_mem_w;
      end
      // Empty decode slots are not bubbles we caused, so only flush/hazard count.
      if (counted_bubble && (cnt_q != '1)) begin
        cnt_q <= cnt_q + CNT_ONE;
      end
    end
  end

  // The memory stage holds the younger result, so it wins over write-back.
  always_comb begin
    fwd_rn = rn_q;
    if (mem_wb_en && (mem_dest == src1_q)) begin
      fwd_rn = mem_value;
    end else if (wb_wb_en && (wb_dest == src1_q)) begin
      fwd_rn = wb_value;
    end
    fwd_rm = rm_q;
    if (mem_wb_en && (mem_dest == src2_q)) begin
      fwd_rm = mem_value;
    end else if (wb_wb_en && (wb_dest == src2_q)) begin
      fwd_rm = wb_value;
    end
  end

  assign alu_in1      = fwd_rn;
  assign alu_in2      = imm_sel_q ? imm_q : fwd_rm;
  assign ex_store_val = fwd_rm;
  assign alu_cmd      = cmd_q;
  assign ex_valid     = valid_q;
  assign ex_wb_en     = wb_en_q;
  assign ex_mem_r     = mem_r_q;
  assign ex_mem_w     = mem_w_q;
  assign ex_dest      = dest_q;
  assign bubble_count = cnt_q;

endmodule

// File: tb/tb_exe_operand_stage.sv
// Scoreboard bench for exe_operand_stage: a per-cycle reference model pushes
// expected outputs, a negedge monitor pops and compares them.
module tb_exe_operand_stage;

  typedef struct packed {
    logic        rst;
    logic        freeze;
    logic        flush;
    logic        id_valid;
    logic [3:0]  cmd;
    logic [31:0] rn;
    logic [31:0] rm;
    logic [31:0] imm;
    logic        imm_sel;
    logic [3:0]  src1;
    logic [3:0]  src2;
    logic [3:0]  dest;
    logic        wb_en;
    logic        mem_r;
    logic        mem_w;
    logic        mem_wb_en;
    logic [3:0]  mem_dest;
    logic [31:0] mem_value;
    logic        wb_wb_en;
    logic [3:0]  wb_dest;
    logic [31:0] wb_value;
  } stim_t;

  typedef struct packed {
    logic        valid;
    logic [3:0]  cmd;
    logic [31:0] rn;
    logic [31:0] rm;
    logic [31:0] imm;
    logic        imm_sel;
    logic [3:0]  src1;
    logic [3:0]  src2;
    logic [3:0]  dest;
    logic        wb_en;
    logic        mem_r;
    logic        mem_w;
  } instr_t;

  typedef struct packed {
    logic        stall;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [3:0]  cmd;
    logic [31:0] store;
    logic        valid;
    logic        wb_en;
    logic        mem_r;
    logic        mem_w;
    logic [3:0]  dest;
    logic [15:0] count;
    logic [1:0]  count2;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, freeze, flush, id_valid, id_imm_sel;
  logic [3:0]  id_cmd, id_src1, id_src2, id_dest;
  logic [31:0] id_val_rn, id_val_rm, id_imm;
  logic        id_wb_en, id_mem_r, id_mem_w;
  logic        mem_wb_en, wb_wb_en;
  logic [3:0]  mem_dest, wb_dest;
  logic [31:0] mem_value, wb_value;

  logic        stall_out, ex_valid, ex_wb_en, ex_mem_r, ex_mem_w;
  logic [31:0] alu_in1, alu_in2, ex_store_val;
  logic [3:0]  alu_cmd, ex_dest;
  logic [15:0] bubble_count;

  logic        stall_out2, ex_valid2, ex_wb_en2, ex_mem_r2, ex_mem_w2;
  logic [31:0] alu_in1_2, alu_in2_2, ex_store_val2;
  logic [3:0]  alu_cmd2, ex_dest2;
  logic [1:0]  bubble_count2;

  exe_operand_stage #(.WIDTH(32), .RADDR(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .id_valid(id_valid),
    .id_cmd(id_cmd), .id_val_rn(id_val_rn), .id_val_rm(id_val_rm), .id_imm(id_imm),
    .id_imm_sel(id_imm_sel), .id_src1(id_src1), .id_src2(id_src2), .id_dest(id_dest),
    .id_wb_en(id_wb_en), .id_mem_r(id_mem_r), .id_mem_w(id_mem_w),
    .mem_wb_en(mem_wb_en), .mem_dest(mem_dest), .mem_value(mem_value),
    .wb_wb_en(wb_wb_en), .wb_dest(wb_dest), .wb_value(wb_value),
    .stall_out(stall_out), .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_cmd(alu_cmd),
    .ex_store_val(ex_store_val), .ex_valid(ex_valid), .ex_wb_en(ex_wb_en),
    .ex_mem_r(ex_mem_r), .ex_mem_w(ex_mem_w), .ex_dest(ex_dest),
    .bubble_count(bubble_count)
  );

  // Narrow-counter copy shares every input; only its counter and a few fields are checked.
  exe_operand_stage #(.WIDTH(32), .RADDR(4), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .id_valid(id_valid),
    .id_cmd(id_cmd), .id_val_rn(id_val_rn), .id_val_rm(id_val_rm), .id_imm(id_imm),
    .id_imm_sel(id_imm_sel), .id_src1(id_src1), .id_src2(id_src2), .id_dest(id_dest),
    .id_wb_en(id_wb_en), .id_mem_r(id_mem_r), .id_mem_w(id_mem_w),
    .mem_wb_en(mem_wb_en), .mem_dest(mem_dest), .mem_value(mem_value),
    .wb_wb_en(wb_wb_en), .wb_dest(wb_dest), .wb_value(wb_value),
    .stall_out(stall_out2), .alu_in1(alu_in1_2), .alu_in2(alu_in2_2), .alu_cmd(alu_cmd2),
    .ex_store_val(ex_store_val2), .ex_valid(ex_valid2), .ex_wb_en(ex_wb_en2),
    .ex_mem_r(ex_mem_r2), .ex_mem_w(ex_mem_w2), .ex_dest(ex_dest2),
    .bubble_count(bubble_count2)
  );

  always #5 clk = ~clk;

  exp_t        exp_q[$];
  instr_t      cur;
  int unsigned bubbles;
  int          checks = 0;
  int          passed = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
  endtask

  function automatic logic [31:0] fwd(input stim_t s, input logic [3:0] tag, input logic [31:0] base);
    if (s.mem_wb_en && s.mem_dest == tag) return s.mem_value;
    if (s.wb_wb_en && s.wb_dest == tag) return s.wb_value;
    return base;
  endfunction

  // Drives one cycle of inputs, records what the outputs must show this cycle,
  // then advances the model to the state the coming edge should produce.
  task automatic applyStimulus(input stim_t s);
    exp_t   e;
    logic   haz;
    instr_t nxt;
    @(posedge clk);
    #1;
    rst = s.rst; freeze = s.freeze; flush = s.flush; id_valid = s.id_valid;
    id_cmd = s.cmd; id_val_rn = s.rn; id_val_rm = s.rm; id_imm = s.imm;
    id_imm_sel = s.imm_sel; id_src1 = s.src1; id_src2 = s.src2; id_dest = s.dest;
    id_wb_en = s.wb_en; id_mem_r = s.mem_r; id_mem_w = s.mem_w;
    mem_wb_en = s.mem_wb_en; mem_dest = s.mem_dest; mem_value = s.mem_value;
    wb_wb_en = s.wb_wb_en; wb_dest = s.wb_dest; wb_value = s.wb_value;

    haz = cur.valid && cur.mem_r && s.id_valid &&
          ((s.src1 == cur.dest) || (!s.imm_sel && s.src2 == cur.dest));
    e = '0;
    e.stall  = s.freeze || (haz && !s.flush);
    e.in1    = fwd(s, cur.src1, cur.rn);
    e.store  = fwd(s, cur.src2, cur.rm);
    e.in2    = cur.imm_sel ? cur.imm : e.store;
    e.cmd    = cur.cmd;
    e.valid  = cur.valid;
    e.wb_en  = cur.wb_en;
    e.mem_r  = cur.mem_r;
    e.mem_w  = cur.mem_w;
    e.dest   = cur.dest;
    e.count  = (bubbles > 65535) ? 16'hFFFF : 16'(bubbles);
    e.count2 = (bubbles > 3) ? 2'd3 : 2'(bubbles);
    exp_q.push_back(e);

    if (s.rst) begin
      cur = '0;
      bubbles = 0;
    end else if (!s.freeze) begin
      if (s.flush || haz) begin
        cur = '0;
        bubbles++;
      end else if (!s.id_valid) begin
        cur = '0;
      end else begin
        nxt = '0;
        nxt.valid = 1'b1; nxt.cmd = s.cmd; nxt.rn = s.rn; nxt.rm = s.rm;
        nxt.imm = s.imm; nxt.imm_sel = s.imm_sel; nxt.src1 = s.src1;
        nxt.src2 = s.src2; nxt.dest = s.dest; nxt.wb_en = s.wb_en;
        nxt.mem_r = s.mem_r; nxt.mem_w = s.mem_w;
        cur = nxt;
      end
    end
  endtask

  function automatic stim_t randStim();
    stim_t s;
    s.rst       = ($urandom_range(0, 49) == 0);
    s.freeze    = ($urandom_range(0, 7) == 0);
    s.flush     = ($urandom_range(0, 7) == 0);
    s.id_valid  = ($urandom_range(0, 3) != 0);
    s.cmd       = 4'($urandom);
    s.rn        = $urandom;
    s.rm        = $urandom;
    s.imm       = $urandom;
    s.imm_sel   = 1'($urandom);
    s.src1      = 4'($urandom_range(0, 3));
    s.src2      = 4'($urandom_range(0, 3));
    s.dest      = 4'($urandom_range(0, 3));
    s.wb_en     = 1'($urandom);
    s.mem_r     = 1'($urandom);
    s.mem_w     = 1'($urandom);
    s.mem_wb_en = 1'($urandom);
    s.mem_dest  = 4'($urandom_range(0, 3));
    s.mem_value = $urandom;
    s.wb_wb_en  = 1'($urandom);
    s.wb_dest   = 4'($urandom_range(0, 3));
    s.wb_value  = $urandom;
    return s;
  endfunction

  function automatic stim_t instr(input logic [3:0] cmd, input logic [31:0] rn, input logic [31:0] rm,
                                  input logic [3:0] src1, input logic [3:0] src2, input logic [3:0] dest,
                                  input logic mem_r);
    stim_t s = '0;
    s.id_valid = 1'b1; s.cmd = cmd; s.rn = rn; s.rm = rm;
    s.src1 = src1; s.src2 = src2; s.dest = dest; s.wb_en = 1'b1; s.mem_r = mem_r;
    return s;
  endfunction

  // Monitor: the DUT presents a result every cycle, compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checkOutput("stall_out", 32'(stall_out), 32'(e.stall));
        checkOutput("ex_valid", 32'(ex_valid), 32'(e.valid));
        checkOutput("ex_wb_en", 32'(ex_wb_en), 32'(e.wb_en));
        checkOutput("ex_mem_r", 32'(ex_mem_r), 32'(e.mem_r));
        checkOutput("ex_mem_w", 32'(ex_mem_w), 32'(e.mem_w));
        checkOutput("bubble_count", 32'(bubble_count), 32'(e.count));
        checkOutput("bubble_count_sat", 32'(bubble_count2), 32'(e.count2));
        checkOutput("ex_valid_sat", 32'(ex_valid2), 32'(e.valid));
        if (e.valid) begin
          checkOutput("alu_in1", alu_in1, e.in1);
          checkOutput("alu_in2", alu_in2, e.in2);
          checkOutput("alu_cmd", 32'(alu_cmd), 32'(e.cmd));
          checkOutput("ex_store_val", ex_store_val, e.store);
          checkOutput("ex_dest", 32'(ex_dest), 32'(e.dest));
        end
      end
    end
  end

  initial begin
    stim_t s;
    stim_t idle;
    idle = '0;
    s = '0;
    s.rst = 1'b1;
    rst = 1'b1; freeze = 0; flush = 0; id_valid = 0; id_cmd = 0; id_val_rn = 0;
    id_val_rm = 0; id_imm = 0; id_imm_sel = 0; id_src1 = 0; id_src2 = 0; id_dest = 0;
    id_wb_en = 0; id_mem_r = 0; id_mem_w = 0; mem_wb_en = 0; mem_dest = 0;
    mem_value = 0; wb_wb_en = 0; wb_dest = 0; wb_value = 0;
    repeat (2) @(posedge clk);
    cur = '0;
    bubbles = 0;

    // Reset held two cycles while decode offers an instruction.
    s = instr(4'h3, 32'hAAAA, 32'hBBBB, 4'd1, 4'd2, 4'd3, 1'b1);
    s.rst = 1'b1;
    applyStimulus(s);
    applyStimulus(s);

    // Plain ADD r3 = 5 + 3.
    applyStimulus(instr(4'b0000, 32'd5, 32'd3, 4'd1, 4'd2, 4'd3, 1'b0));
    @(negedge clk);
    checkOutput("reset_ex_valid", 32'(ex_valid), 32'd0);
    checkOutput("reset_alu_cmd", 32'(alu_cmd), 32'd0);
    checkOutput("reset_bubble_count", 32'(bubble_count), 32'd0);
    applyStimulus(idle);
    @(negedge clk);
    checkOutput("add_alu_in1", alu_in1, 32'd5);
    checkOutput("add_alu_in2", alu_in2, 32'd3);
    checkOutput("add_ex_valid", 32'(ex_valid), 32'd1);

    // Forwarding priority on src1 = R2, held in place by freeze.
    applyStimulus(instr(4'h4, 32'h99, 32'h77, 4'd2, 4'd6, 4'd7, 1'b0));
    s = idle;
    s.freeze = 1'b1;
    s.mem_wb_en = 1'b1; s.mem_dest = 4'd2; s.mem_value = 32'h11;
    s.wb_wb_en = 1'b1; s.wb_dest = 4'd2; s.wb_value = 32'h22;
    applyStimulus(s);
    @(negedge clk);
    checkOutput("fwd_mem_priority", alu_in1, 32'h11);
    s.mem_wb_en = 1'b0;
    applyStimulus(s);
    @(negedge clk);
    checkOutput("fwd_wb", alu_in1, 32'h22);

    // Load-use: LDR r4 followed by SUB using r4.
    applyStimulus(instr(4'h5, 32'h100, 32'h0, 4'd1, 4'd2, 4'd4, 1'b1));
    applyStimulus(instr(4'b0010, 32'h40, 32'h8, 4'd4, 4'd5, 4'd6, 1'b0));
    @(negedge clk);
    checkOutput("loaduse_stall", 32'(stall_out), 32'd1);
    applyStimulus(instr(4'b0010, 32'h40, 32'h8, 4'd4, 4'd5, 4'd6, 1'b0));
    @(negedge clk);
    checkOutput("loaduse_bubble_valid", 32'(ex_valid), 32'd0);
    checkOutput("loaduse_bubble_count", 32'(bubble_count), 32'd1);
    checkOutput("loaduse_stall_clear", 32'(stall_out), 32'd0);
    applyStimulus(idle);
    @(negedge clk);
    checkOutput("loaduse_sub_loaded", 32'(alu_cmd), 32'b0010);

    // Flush arriving with a pending hazard.
    applyStimulus(instr(4'h5, 32'h200, 32'h0, 4'd1, 4'd2, 4'd5, 1'b1));
    s = instr(4'b0010, 32'h1, 32'h2, 4'd5, 4'd1, 4'd6, 1'b0);
    s.flush = 1'b1;
    applyStimulus(s);
    @(negedge clk);
    checkOutput("flush_hazard_stall", 32'(stall_out), 32'd0);
    applyStimulus(idle);
    @(negedge clk);
    checkOutput("flush_bubble_valid", 32'(ex_valid), 32'd0);
    checkOutput("flush_bubble_count", 32'(bubble_count), 32'd2);

    // Freeze for three cycles, the first also carrying a flush.
    applyStimulus(instr(4'h9, 32'h1234, 32'h5678, 4'd7, 4'd8, 4'd9, 1'b0));
    for (int i = 0; i < 3; i++) begin
      s = instr(4'h1, 32'hDEAD, 32'hBEEF, 4'd9, 4'd9, 4'd1, 1'b0);
      s.freeze = 1'b1;
      s.flush = (i == 0);
      applyStimulus(s);
      @(negedge clk);
      checkOutput("freeze_stall", 32'(stall_out), 32'd1);
      checkOutput("freeze_alu_in1", alu_in1, 32'h1234);
      checkOutput("freeze_alu_cmd", 32'(alu_cmd), 32'h9);
    end
    applyStimulus(idle);
    @(negedge clk);
    checkOutput("freeze_count_held", 32'(bubble_count), 32'd2);

    // Saturation of the 2-bit counter after five flushes.
    s = idle;
    s.rst = 1'b1;
    applyStimulus(s);
    s = idle;
    s.flush = 1'b1;
    repeat (5) applyStimulus(s);
    applyStimulus(idle);
    @(negedge clk);
    checkOutput("sat_count", 32'(bubble_count2), 32'd3);
    checkOutput("wide_count", 32'(bubble_count), 32'd5);
    applyStimulus(s);
    applyStimulus(idle);
    @(negedge clk);
    checkOutput("sat_count_hold", 32'(bubble_count2), 32'd3);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      applyStimulus(randStim());
    end
    applyStimulus(idle);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
